booth_mult_sched: RTL and testbench



---
 rtl/booth_pkg.sv | 34 +++
 rtl/booth_digit_enc.sv | 27 ++
 rtl/booth_mult_sched.sv | 148 ++++++++++++++
 tb/tb_booth_mult_sched.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiply engine.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_e;

  // Partial-product selection for one radix-4 Booth digit.
  typedef enum logic [2:0] {
    ZERO,
    PM,
    P2M,
    NM,
    N2M
  } booth_sel_e;

  function automatic int BOOTH_ITERS(input int width);
    return width / 2;
  endfunction

  // Digit {q[2k+1], q[2k], q[2k-1]} selects 0, +M, +2M, -2M or -M.
  function automatic booth_sel_e booth_sel(input logic [2:0] digit);
    case (digit)
      3'b001, 3'b010: return PM;
      3'b011:         return P2M;
      3'b100:         return N2M;
      3'b101, 3'b110: return NM;
      default:        return ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Combinational radix-4 Booth digit encoder: one 3-bit digit and multiplicand
// in, sign-extended double-width partial product out.
module booth_digit_enc
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]         digit_i,
  input  logic [WIDTH-1:0]   m_i,
  output logic [2*WIDTH-1:0] pp_o
);

  logic [2*WIDTH-1:0] m_ext;

  assign m_ext = {{WIDTH{m_i[WIDTH-1]}}, m_i};

  always_comb begin
    case (booth_sel(digit_i))
      PM:      pp_o = m_ext;
      P2M:     pp_o = m_ext << 1;
      NM:      pp_o = -m_ext;
      N2M:     pp_o = -(m_ext << 1);
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/booth_mult_sched.sv
// Two-requester round-robin front end sharing one iterative radix-4 Booth
// multiplier; one Booth digit is accumulated per clock.
module booth_mult_sched
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   m0,
  input  logic [WIDTH-1:0]   q0,
  input  logic [WIDTH-1:0]   m1,
  input  logic [WIDTH-1:0]   q1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               done0,
  output logic               done1,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int ITERS = BOOTH_ITERS(WIDTH);
  localparam int CNT_W = $clog2(ITERS);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mreg_q, mreg_d, qreg_q, qreg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, p_q, p_d;
  logic               last_q, last_d;   // index of the requester granted most recently
  logic               win_q, win_d;     // requester owning the current operation
  logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic               done0_q, done0_d, done1_q, done1_d;
  logic               busy_q, busy_d;

  logic               pick1;
  logic [WIDTH:0]     q_ext;
  logic [2:0]         digit;
  logic [2*WIDTH-1:0] pp, acc_sum;

  // Requester 1 wins when alone, or on a tie when requester 0 went last.
  assign pick1   = req1 & (~req0 | ~last_q);
  assign q_ext   = {qreg_q, 1'b0};
  assign digit   = 3'(q_ext >> {cnt_q, 1'b0});
  assign acc_sum = acc_q + (pp << {cnt_q, 1'b0});

  booth_digit_enc #(.WIDTH(WIDTH)) u_enc (
    .digit_i (digit),
    .m_i     (mreg_q),
    .pp_o    (pp)
  );

  // NOTE: every variable gets its default before the case so no path leaves
  // one unassigned, which is what keeps this block from inferring latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mreg_d  = mreg_q;
    qreg_d  = qreg_q;
    acc_d   = acc_q;
    p_d     = p_q;
    last_d  = last_q;
    win_d   = win_q;
    busy_d  = busy_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          win_d   = pick1;
          mreg_d  = pick1 ? m1 : m0;
          qreg_d  = pick1 ? q1 : q0;
          acc_d   = '0;
          cnt_d   = '0;
          gnt0_d  = ~pick1;
          gnt1_d  = pick1;
          busy_d  = 1'b1;
          state_d = ITER;
        end
      end
      ITER: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_W'(1);
        // The final digit lands straight in p so done and p share a cycle.
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          p_d     = acc_sum;
          done0_d = ~win_q;
          done1_d = win_q;
          state_d = DONE;
        end
      end
      DONE: begin
        last_d  = win_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      busy_q  <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      last_q  <= last_d;
      win_q   <= win_d;
      busy_q  <= busy_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  // NOTE: operand registers are always loaded at grant before they are read,
  // so they carry no reset.
  always_ff @(posedge clk) begin
    mreg_q <= mreg_d;
    qreg_q <= qreg_d;
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign p     = p_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_booth_mult_sched.sv
// Randomised scoreboard bench for booth_mult_sched against a signed-multiply
// and round-robin reference model.
module tb_booth_mult_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] m0 = '0, q0 = '0, m1 = '0, q1 = '0;
  logic        gnt0, gnt1, done0, done1, busy;
  logic [63:0] p;

  typedef struct {
    bit          id;
    logic [63:0] p;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   gnt_cyc = 0;
  bit   in_flight = 0;
  bit   tb_last = 1'b1;

  booth_mult_sched #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .req1  (req1),
    .m0    (m0),
    .q0    (q0),
    .m1    (m1),
    .q1    (q1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .done0 (done0),
    .done1 (done1),
    .p     (p),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model_prod(input logic [31:0] m, input logic [31:0] q);
    longint a, b;
    a = longint'($signed(m));
    b = longint'($signed(q));
    return 64'(a * b);
  endfunction

  // Monitor: pops the scoreboard on every done and tracks grant-to-done framing.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      in_flight = 0;
    end else begin
      if (gnt0 | gnt1) begin
        check("gnt_onehot", 64'(gnt0 & gnt1), 64'd0);
        gnt_cyc   = cyc;
        in_flight = 1;
      end
      if (in_flight) check("busy_held", 64'(busy), 64'd1);
      if (done0 | done1) begin
        check("done_onehot", 64'(done0 & done1), 64'd0);
        check("done_latency", 64'(cyc - gnt_cyc), 64'd16);
        check("done_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("done_id", 64'(done1), 64'(e.id));
          check("product", p, e.p);
        end
        in_flight = 0;
      end
    end
  end

  task automatic wait_done(input bit id);
    int n = 0;
    while (!(id ? done1 : done0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 64'(id ? done1 : done0), 64'd1);
  endtask

  task automatic run_one(input bit id, input logic [31:0] m, input logic [31:0] q,
                         input bit late_drop);
    exp_t e;
    if (id) begin m1 = m; q1 = q; req1 = 1'b1; end
    else    begin m0 = m; q0 = q; req0 = 1'b1; end
    e.id = id;
    e.p  = model_prod(m, q);
    sb.push_back(e);
    tb_last = id;
    @(negedge clk);
    check("gnt_latency", 64'({gnt1, gnt0}), id ? 64'd2 : 64'd1);
    if (late_drop) repeat (5) @(negedge clk);
    // Operands and requests move after capture; the result must not follow.
    m0 = $urandom; q0 = $urandom; m1 = $urandom; q1 = $urandom;
    req0 = 1'b0; req1 = 1'b0;
    wait_done(id);
    @(negedge clk);
  endtask

  task automatic tie_run(input int n);
    exp_t e;
    bit   w;
    int   prev = 0;
    int   k_wait;
    m0 = $urandom; q0 = $urandom; m1 = $urandom; q1 = $urandom;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < n; i++) begin
      w    = ~tb_last;
      e.id = w;
      e.p  = w ? model_prod(m1, q1) : model_prod(m0, q0);
      sb.push_back(e);
      tb_last = w;
    end
    @(negedge clk);
    check("tie_first_gnt", 64'({gnt1, gnt0}), (n > 0 && sb[sb.size()-n].id) ? 64'd2 : 64'd1);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      k_wait = 0;
      while (!(done0 | done1) && k_wait < 40) begin
        @(negedge clk);
        k_wait++;
      end
      check("tie_done_seen", 64'(done0 | done1), 64'd1);
      if (k > 0) check("done_spacing", 64'(cyc - prev), 64'd18);
      prev = cyc;
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ctrl", 64'({gnt0, gnt1, done0, done1, busy}), 64'd0);
    check("rst_p", p, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_one(1'b0, 32'd3, 32'd5, 1'b0);
    check("p_3x5", p, 64'd15);
    run_one(1'b1, 32'hFFFF_FFF9, 32'd6, 1'b0);
    check("p_m7x6", p, 64'hFFFF_FFFF_FFFF_FFD6);
    run_one(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check("p_minxmin", p, 64'h4000_0000_0000_0000);
    run_one(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("p_m1xm1", p, 64'd1);

    tie_run(4);

    run_one(1'b0, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);

    // Leave requester 0 as most recent, then kill a fresh operation mid-ITER.
    m0 = $urandom; q0 = $urandom; req0 = 1'b1;
    @(negedge clk);
    check("rst_txn_gnt", 64'(gnt0), 64'd1);
    req0 = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ctrl", 64'({gnt0, gnt1, done0, done1, busy}), 64'd0);
    check("midrst_p", p, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tb_last = 1'b1;
    repeat (25) @(negedge clk);
    tie_run(2);

    for (int i = 0; i < 1000; i++) begin
      run_one(1'($urandom_range(0, 1)), $urandom, $urandom, (i % 8) == 0);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
